// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encodings and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fl_add_1b.sv
// One-bit full-adder cell; purely combinational, sequenced over time by
// serial_add_ctrl.
module fl_add_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ ci;
  assign c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: runs a single fl_add_1b cell over WIDTH cycles,
// LSB first, with a flip-flop carrying the carry between bits.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             msb_carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;

  fl_add_1b u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (bit_s),
    .c  (bit_c)
  );

  assign last = (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so the inversion happens once at load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      msb_carry <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum   <= {bit_s, sum[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        msb_carry <= carry;
        cout      <= bit_c;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign ovf  = msb_carry ^ cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8; each task
// drives one scenario and compares against hand-computed results.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one operation for a single accepting edge; returns at the
  // negedge after that edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tsub, input logic tcin);
    @(negedge clk);
    a = ta;
    b = tb_v;
    sub = tsub;
    cin = tcin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cycles, output bit seen);
    edges = 0;
    seen = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("[TB] FAIL reset_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_add;
    int edges, bc;
    bit seen;
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy_start: got %b expected 1", busy); end
    wait_done(edges, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL add_done_seen: got %b expected 1", seen); end
    checks++; if (edges != 8) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 8", edges); end
    checks++; if (bc != 8) begin errors++; $display("[TB] FAIL add_busy_cycles: got %0d expected 8", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL add_busy_at_done: got %b expected 0", busy); end
    checks++; if (sum !== 8'h96) begin errors++; $display("[TB] FAIL add_sum: got %h expected 96", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL add_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL add_ovf: got %b expected 1", ovf); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL add_done_width: got %b expected 0", done); end
    checks++; if (sum !== 8'h96) begin errors++; $display("[TB] FAIL add_sum_hold: got %h expected 96", sum); end
  endtask

  task automatic test_add_carry;
    int edges, bc;
    bit seen;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(edges, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL carry_done_seen: got %b expected 1", seen); end
    checks++; if (sum !== 8'h00) begin errors++; $display("[TB] FAIL carry_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("[TB] FAIL carry_cout: got %b expected 1", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL carry_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_mid_run;
    int edges, bc;
    bit seen;
    bit stray_done;
    bit stray_busy;
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    checks++; if (sum !== 8'h00) begin errors++; $display("[TB] FAIL midrst_sum: got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf); end
    rst_n = 1'b1;
    stray_done = 1'b0;
    stray_busy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) stray_done = 1'b1;
      if (busy) stray_busy = 1'b1;
    end
    checks++; if (stray_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done: got %b expected 0", stray_done); end
    checks++; if (stray_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_busy: got %b expected 0", stray_busy); end
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(edges, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL midrst_after_seen: got %b expected 1", seen); end
    checks++; if (sum !== 8'h02) begin errors++; $display("[TB] FAIL midrst_after_sum: got %h expected 02", sum); end
  endtask

  task automatic test_sub;
    int edges, bc;
    bit seen;
    start_op(8'h05, 8'h07, 1'b1, 1'b0);
    wait_done(edges, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL sub_done_seen: got %b expected 1", seen); end
    checks++; if (edges != 8) begin errors++; $display("[TB] FAIL sub_latency: got %0d expected 8", edges); end
    checks++; if (sum !== 8'hFE) begin errors++; $display("[TB] FAIL sub_sum: got %h expected fe", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL sub_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_ignore_start;
    int edges, bc;
    bit seen;
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    a = 8'hFF;
    b = 8'hFF;
    sub = 1'b1;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(edges, bc, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done_seen: got %b expected 1", seen); end
    checks++; if (edges != 6) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 6", edges); end
    checks++; if (sum !== 8'h30) begin errors++; $display("[TB] FAIL ignore_sum: got %h expected 30", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL ignore_cout: got %b expected 0", cout); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_restart: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int done_count, accept_count;
    int last_done, last_accept;
    bit prev_busy, prev_done;
    done_count = 0;
    accept_count = 0;
    last_done = -1;
    last_accept = -1;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    sub = 1'b0;
    cin = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        checks++;
        if (i != accept_count * 10) begin errors++; $display("[TB] FAIL b2b_accept_edge: got %0d expected %0d", i, accept_count * 10); end
        accept_count++;
        last_accept = i;
      end
      if (done) begin
        checks++;
        if (prev_done) begin errors++; $display("[TB] FAIL b2b_done_consecutive: got 1 expected 0 at %0d", i); end
        checks++;
        if (i != 8 + done_count * 10) begin errors++; $display("[TB] FAIL b2b_done_edge: got %0d expected %0d", i, 8 + done_count * 10); end
        checks++;
        if (sum !== 8'h33) begin errors++; $display("[TB] FAIL b2b_sum: got %h expected 33", sum); end
        done_count++;
        last_done = i;
      end
      prev_busy = busy;
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (done_count != 4) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", done_count); end
    checks++; if (accept_count != 4) begin errors++; $display("[TB] FAIL b2b_accept_count: got %0d expected 4", accept_count); end
    checks++; if (last_done != 38) begin errors++; $display("[TB] FAIL b2b_last_done: got %0d expected 38", last_done); end
    checks++; if (last_accept != 30) begin errors++; $display("[TB] FAIL b2b_last_accept: got %0d expected 30", last_accept); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    cin = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset;
    test_add;
    test_add_carry;
    test_reset_mid_run;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
